// File: rtl/vending_pkg.sv
// Shared definitions for the vending-machine controller: mode codes, FSM states,
// error bit positions and the item price table.
package vending_pkg;

  localparam logic [1:0] MODE_IDLE    = 2'd0;
  localparam logic [1:0] MODE_BUY     = 2'd1;
  localparam logic [1:0] MODE_RESTOCK = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int ERR_TYPE  = 0;
  localparam int ERR_MONEY = 1;
  localparam int ERR_STOCK = 2;
  localparam int ERR_ZERO  = 3;
  localparam int ERR_OVFL  = 4;
  localparam int ERR_MODE  = 5;
  localparam int ERR_EMPTY = 6;

  localparam int MAX_TYPES = 6;
  localparam logic [3:0] PRICE [MAX_TYPES] = '{4'd5, 4'd8, 4'd10, 4'd12, 4'd3, 4'd7};

  typedef struct packed {
    logic [1:0] mode;
    logic [6:0] money;
    logic [2:0] stype;
    logic [3:0] amount;
    logic [3:0] add;
  } req_t;

  // Unknown item codes cost nothing; their requests are flagged invalid elsewhere.
  function automatic logic [7:0] item_cost(input logic [2:0] t, input logic [3:0] n);
    logic [3:0] p;
    p = 4'd0;
    for (int i = 0; i < MAX_TYPES; i++) begin
      if (t == 3'(i)) p = PRICE[i];
    end
    return {4'd0, p} * {4'd0, n};
  endfunction

endpackage

// File: rtl/vending_stock_ram.sv
// Per-item stock register file: one combinational read port, one write port,
// plus an "any entry empty once the pending write lands" flag.
module vending_stock_ram
  import vending_pkg::*;
#(
  parameter int         DEPTH = 6,
  parameter logic [3:0] INIT  = 4'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] rd_addr,
  output logic [3:0] rd_data,
  input  logic       we,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic       any_empty_next
);

  logic [3:0] mem [DEPTH];
  logic [3:0] val_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we && wr_addr == 3'(i)) mem[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = 4'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == 3'(i)) rd_data = mem[i];
    end
  end

  always_comb begin
    any_empty_next = 1'b0;
    val_next       = 4'd0;
    for (int i = 0; i < DEPTH; i++) begin
      val_next = (we && wr_addr == 3'(i)) ? wr_data : mem[i];
      if (val_next == 4'd0) any_empty_next = 1'b1;
    end
  end

endmodule

// File: rtl/vending_main.sv
// Vending-machine request controller: validates purchase/restock requests against
// the stock table. Optional change output enabled by macro VM_CHANGE_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a new request (mode != 0, tuple differs from captured)
// ST_CHECK  | evaluate error bits from the captured request
// ST_COMMIT | update stock on success, register error/redLight
// ST_HOLD   | error held; new request re-enters CHECK, mode 0 returns to IDLE
module vending_main
  import vending_pkg::*;
#(
  parameter int INIT_STOCK = 5,
  parameter int NUM_TYPES  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [6:0] customer_money,
  input  logic [2:0] supply_type,
  input  logic [3:0] customer_amount,
  input  logic [3:0] amount_sypply_to_add,
  output logic [6:0] error,
  output logic       redLight
`ifdef VM_CHANGE_EN
  ,
  output logic [6:0] change
`endif
);

  localparam logic [3:0] NUM_T = 4'(NUM_TYPES);

  state_t     state, state_nxt;
  req_t       req_in, req_q;
  logic       new_req, capture;
  logic [5:0] err_calc, err_chk;
  logic [3:0] stock_rd, stock_wr;
  logic       stock_we, any_empty;
  logic       type_bad, is_buy, is_rst, commit_ok;
  logic [7:0] cost;
  logic [4:0] stock_sum;

  assign req_in  = '{mode: mode, money: customer_money, stype: supply_type,
                     amount: customer_amount, add: amount_sypply_to_add};
  assign new_req = (mode != MODE_IDLE) && (req_in != req_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (new_req) begin
          capture   = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK:  state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (new_req) begin
          capture   = 1'b1;
          state_nxt = ST_CHECK;
        end else if (mode == MODE_IDLE) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       req_q <= '0;
    else if (capture) req_q <= req_in;
  end

  assign type_bad  = {1'b0, req_q.stype} >= NUM_T;
  assign is_buy    = req_q.mode == MODE_BUY;
  assign is_rst    = req_q.mode == MODE_RESTOCK;
  assign cost      = item_cost(req_q.stype, req_q.amount);
  assign stock_sum = {1'b0, stock_rd} + {1'b0, req_q.add};

  // An invalid item code masks the checks that would index the stock/price tables.
  always_comb begin
    err_calc = '0;
    if (req_q.mode == MODE_ILLEGAL) begin
      err_calc[ERR_MODE] = 1'b1;
    end else begin
      err_calc[ERR_TYPE] = type_bad;
      err_calc[ERR_ZERO] = (is_buy && req_q.amount == 4'd0) || (is_rst && req_q.add == 4'd0);
      if (!type_bad) begin
        err_calc[ERR_MONEY] = is_buy && ({1'b0, req_q.money} < cost);
        err_calc[ERR_STOCK] = is_buy && (req_q.amount > stock_rd);
        err_calc[ERR_OVFL]  = is_rst && (stock_sum > 5'd15);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 err_chk <= '0;
    else if (state == ST_CHECK) err_chk <= err_calc;
  end

  assign commit_ok = (state == ST_COMMIT) && (err_chk == 6'd0);
  assign stock_we  = commit_ok && (is_buy || is_rst);
  assign stock_wr  = is_buy ? (stock_rd - req_q.amount) : stock_sum[3:0];

  vending_stock_ram #(
    .DEPTH (MAX_TYPES),
    .INIT  (4'(INIT_STOCK))
  ) u_stock (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_addr        (req_q.stype),
    .rd_data        (stock_rd),
    .we             (stock_we),
    .wr_addr        (req_q.stype),
    .wr_data        (stock_wr),
    .any_empty_next (any_empty)
  );

  // Illegal-mode requests report only the mode bit, so the empty warning is masked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error    <= '0;
      redLight <= 1'b0;
    end else if (state == ST_COMMIT) begin
      error    <= {any_empty && !err_chk[ERR_MODE], err_chk};
      redLight <= |err_chk;
    end
  end

`ifdef VM_CHANGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change <= '0;
    end else if (state == ST_COMMIT) begin
      if (commit_ok && is_buy) change <= req_q.money - cost[6:0];
      else                     change <= req_q.money;
    end
  end
`endif

endmodule

// File: tb/tb_vending_main.sv
// Directed self-checking bench for vending_main (change output checked when VM_CHANGE_EN is defined).
module tb_vending_main;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic [6:0] customer_money;
  logic [2:0] supply_type;
  logic [3:0] customer_amount;
  logic [3:0] amount_sypply_to_add;
  logic [6:0] error;
  logic       redLight;
`ifdef VM_CHANGE_EN
  logic [6:0] change;
`endif

  int n_cmp;
  int n_err;

  vending_main dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .mode                 (mode),
    .customer_money       (customer_money),
    .supply_type          (supply_type),
    .customer_amount      (customer_amount),
    .amount_sypply_to_add (amount_sypply_to_add),
    .error                (error),
    .redLight             (redLight)
`ifdef VM_CHANGE_EN
    ,
    .change               (change)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [6:0] money, input logic [2:0] t,
                       input logic [3:0] amt, input logic [3:0] add);
    @(negedge clk);
    mode                 = m;
    customer_money       = money;
    supply_type          = t;
    customer_amount      = amt;
    amount_sypply_to_add = add;
  endtask

  task automatic req(input logic [1:0] m, input logic [6:0] money, input logic [2:0] t,
                     input logic [3:0] amt, input logic [3:0] add);
    drive(m, money, t, amt, add);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_stock(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                           input logic [3:0] e2, input logic [3:0] e3,
                           input logic [3:0] e4, input logic [3:0] e5);
    chk({tag, "_s0"}, 32'(dut.u_stock.mem[0]), 32'(e0));
    chk({tag, "_s1"}, 32'(dut.u_stock.mem[1]), 32'(e1));
    chk({tag, "_s2"}, 32'(dut.u_stock.mem[2]), 32'(e2));
    chk({tag, "_s3"}, 32'(dut.u_stock.mem[3]), 32'(e3));
    chk({tag, "_s4"}, 32'(dut.u_stock.mem[4]), 32'(e4));
    chk({tag, "_s5"}, 32'(dut.u_stock.mem[5]), 32'(e5));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    mode = 2'd0; customer_money = 7'd0; supply_type = 3'd0;
    customer_amount = 4'd0; amount_sypply_to_add = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_error", 32'(error), 32'h00);
    chk("rst_red", 32'(redLight), 32'h0);
    chk_stock("rst", 5, 5, 5, 5, 5, 5);
    @(negedge clk);
    rst_n = 1'b1;

    // buy 2 of item 0 (cost 10) with 20
    req(2'd1, 7'd20, 3'd0, 4'd2, 4'd0);
    chk("buy0_error", 32'(error), 32'h00);
    chk("buy0_red", 32'(redLight), 32'h0);
    chk("buy0_stock", 32'(dut.u_stock.mem[0]), 32'd3);
`ifdef VM_CHANGE_EN
    chk("buy0_change", 32'(change), 32'd10);
`endif
    repeat (6) @(posedge clk);
    #1;
    chk("hold_no_redecrement", 32'(dut.u_stock.mem[0]), 32'd3);
    chk("hold_error", 32'(error), 32'h00);

    // buy 1 of item 1 (cost 8) with 10
    req(2'd1, 7'd10, 3'd1, 4'd1, 4'd0);
    chk("buy1_error", 32'(error), 32'h00);
    chk("buy1_stock", 32'(dut.u_stock.mem[1]), 32'd4);
`ifdef VM_CHANGE_EN
    chk("buy1_change", 32'(change), 32'd2);
`endif

    // buy 4 of item 5 (cost 28) with 1 -> insufficient money
    req(2'd1, 7'd1, 3'd5, 4'd4, 4'd0);
    chk("money_error", 32'(error), 32'h02);
    chk("money_red", 32'(redLight), 32'h1);
    chk("money_stock", 32'(dut.u_stock.mem[5]), 32'd5);
`ifdef VM_CHANGE_EN
    chk("money_change", 32'(change), 32'd1);
`endif

    // invalid type 6
    req(2'd1, 7'd15, 3'd6, 4'd3, 4'd0);
    chk("type_error", 32'(error), 32'h01);
    chk("type_red", 32'(redLight), 32'h1);
    chk_stock("type", 3, 4, 5, 5, 5, 5);

    // restock item 2 by 11 -> overflow, then by 10 -> 15
    req(2'd2, 7'd0, 3'd2, 4'd0, 4'd11);
    chk("ovfl_error", 32'(error), 32'h10);
    chk("ovfl_stock", 32'(dut.u_stock.mem[2]), 32'd5);
    req(2'd2, 7'd0, 3'd2, 4'd0, 4'd10);
    chk("rst10_error", 32'(error), 32'h00);
    chk("rst10_red", 32'(redLight), 32'h0);
    chk("rst10_stock", 32'(dut.u_stock.mem[2]), 32'd15);

    // buy 4 of item 0 with only 3 left
    req(2'd1, 7'd127, 3'd0, 4'd4, 4'd0);
    chk("stock_error", 32'(error), 32'h04);
    chk("stock_stock", 32'(dut.u_stock.mem[0]), 32'd3);

    // zero quantity
    req(2'd1, 7'd50, 3'd0, 4'd0, 4'd0);
    chk("zero_error", 32'(error), 32'h08);

    // money exactly equals cost: 3 of item 4 at 3 each
    req(2'd1, 7'd9, 3'd4, 4'd3, 4'd0);
    chk("exact_error", 32'(error), 32'h00);
    chk("exact_stock", 32'(dut.u_stock.mem[4]), 32'd2);
`ifdef VM_CHANGE_EN
    chk("exact_change", 32'(change), 32'd0);
`endif

    // empty item 0 -> informational empty warning only
    req(2'd1, 7'd127, 3'd0, 4'd3, 4'd0);
    chk("empty_error", 32'(error), 32'h40);
    chk("empty_red", 32'(redLight), 32'h0);
    chk("empty_stock", 32'(dut.u_stock.mem[0]), 32'd0);
`ifdef VM_CHANGE_EN
    chk("empty_change", 32'(change), 32'd112);
`endif

    // mode 0 returns to idle with error held
    drive(2'd0, 7'd0, 3'd0, 4'd0, 4'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_hold_error", 32'(error), 32'h40);

    // illegal mode
    req(2'd3, 7'd33, 3'd1, 4'd1, 4'd1);
    chk("illegal_error", 32'(error), 32'h20);
    chk("illegal_red", 32'(redLight), 32'h1);
`ifdef VM_CHANGE_EN
    chk("illegal_change", 32'(change), 32'd33);
`endif

    // reset while in CHECK aborts and restores stock
    drive(2'd1, 7'd50, 3'd1, 4'd1, 4'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_error", 32'(error), 32'h00);
    chk("midrst_red", 32'(redLight), 32'h0);
    chk_stock("midrst", 5, 5, 5, 5, 5, 5);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
